ff_chain_sequencer: RTL

Flow-controlled sequencer for an N-stage, DW-bit flip-flop delay chain. It shifts words through the chain only on accepted transfers and tracks per-stage valid bits and occupancy. It drains the chain on command, so a fixed-latency register pipeline can sit between valid/ready producers and consumers. It sits between a stimulus or producer stage and any block that needs a word delayed by exactly N accepted inputs.

---
 rtl/ff_chain_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/ff_chain_sequencer.sv
// Flow-controlled N-stage delay chain: words advance only on accepted transfers,
// and a flush command pushes bubbles in until every held word has left.
module ff_chain_sequencer #(
    parameter  int N  = 10,
    parameter  int DW = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [1:0]    state,
    output logic          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [DW-1:0] dataChain_q [N];
    logic [N-1:0]  validChain_q;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          flushing, shift, outXfer;

    // While draining, the chain advances whenever the last stage can move on.
    always_comb begin
        flushing = (state_q == FLUSH);
        in_ready = !flushing && (!validChain_q[N-1] || out_ready);
        shift    = flushing ? (!validChain_q[N-1] || out_ready)
                            : (in_valid && in_ready);
        outXfer  = shift && validChain_q[N-1];

        count_d = count_q;
        if (shift && !flushing && !outXfer) begin
            count_d = count_q + CW'(1);
        end else if (outXfer && flushing) begin
            count_d = count_q - CW'(1);
        end

        state_d = state_q;
        if (!flushing && flush && (count_d != '0)) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (count_d != '0)     state_d = FILL;
                FILL:    if (count_d == CW'(N)) state_d = FULL;
                FLUSH:   if (count_d == '0)     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                dataChain_q[i] <= '0;
            end
            validChain_q <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
        end else begin
            if (shift) begin
                for (int i = N - 1; i > 0; i--) begin
                    dataChain_q[i] <= dataChain_q[i-1];
                end
                dataChain_q[0] <= flushing ? '0 : in_data;
                validChain_q   <= {validChain_q[N-2:0], !flushing};
            end
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign out_data  = dataChain_q[N-1];
    assign out_valid = validChain_q[N-1];
    assign count     = count_q;
    assign state     = state_q;
    assign busy      = (state_q != IDLE);

endmodule
